// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and
// width helpers used by the top and the round-robin picker.
package shared_reg_arbiter_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_elig at or after i_ptr,
// wrapping, found by scanning a doubled copy of the request vector.
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    i_elig,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_any,
    output logic [IDXW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_shift;
    int             w_off;
    int             w_sum;

    always_comb begin
        w_dbl   = {i_elig, i_elig};
        w_shift = w_dbl >> i_ptr;
        o_any   = 1'b0;
        w_off   = 0;
        // Descending scan so the lowest offset from the pointer wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_shift[k]) begin
                o_any = 1'b1;
                w_off = k;
            end
        end
        w_sum = int'(i_ptr) + w_off;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        o_idx = IDXW'(w_sum);
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write controller for one shared WIDTH-bit register,
// with optional bounded lock ownership for bursts from a single requester.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int WIDTH    = 8,
    parameter  int MAX_HOLD = 4,
    localparam int IDXW     = idx_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       lock,
    input  logic [N*WIDTH-1:0] wdata,
    output logic [N-1:0]       gnt,
    output logic [WIDTH-1:0]   q,
    output logic [IDXW-1:0]    owner,
    output logic               owner_valid
);

    localparam int CW = cnt_width(MAX_HOLD);

    logic [0:0]       r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [CW-1:0]    r_hold;
    logic [N-1:0]     r_gnt;
    logic [WIDTH-1:0] r_q;
    logic [IDXW-1:0]  r_owner;
    logic             r_owner_valid;

    logic [N-1:0]     w_elig;
    logic             w_any;
    logic [IDXW-1:0]  w_idx;
    logic [N-1:0]     w_onehot;
    logic [IDXW-1:0]  w_ptr_next;
    logic [WIDTH-1:0] w_wr_data;
    logic [CW-1:0]    w_hold_inc;
    logic             w_last;

    // A requester is never eligible in its own ack cycle; a lock narrows to the owner.
    always_comb begin
        w_elig = req & ~r_gnt;
        if (r_state == ST_LOCKED) begin
            w_elig          = '0;
            w_elig[r_owner] = req[r_owner] & ~r_gnt[r_owner];
        end
    end

    rr_pick #(.N(N)) u_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign w_onehot[gi] = (int'(w_idx) == gi);
        end
    endgenerate

    always_comb begin
        if (int'(w_idx) >= N - 1) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_idx + 1'b1;
        end
    end

    assign w_wr_data  = wdata[w_idx*WIDTH +: WIDTH];
    assign w_hold_inc = r_hold + 1'b1;
    assign w_last     = (w_hold_inc == CW'(MAX_HOLD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_hold        <= '0;
            r_gnt         <= '0;
            r_q           <= '0;
            r_owner       <= '0;
            r_owner_valid <= 1'b0;
        end else begin
            r_gnt <= '0;
            if (w_any) begin
                r_q     <= w_wr_data;
                r_gnt   <= w_onehot;
                r_owner <= w_idx;
                r_ptr   <= w_ptr_next;
            end
            case (r_state)
                ST_IDLE: begin
                    // With MAX_HOLD of 1 the first write already exhausts the burst.
                    if (w_any && lock[w_idx] && (MAX_HOLD > 1)) begin
                        r_state       <= ST_LOCKED;
                        r_hold        <= CW'(1);
                        r_owner_valid <= 1'b1;
                    end
                end
                default: begin
                    if (!lock[r_owner] || (w_any && w_last)) begin
                        r_state       <= ST_IDLE;
                        r_hold        <= '0;
                        r_owner_valid <= 1'b0;
                    end else if (w_any) begin
                        r_hold <= w_hold_inc;
                    end
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign q           = r_q;
    assign owner       = r_owner;
    assign owner_valid = r_owner_valid;

endmodule
